countdown_timer: RTL and testbench

Loadable down-counting timer with a run/pause FSM. It is the decrementing counterpart of the lab's free-running 0..7 up-counter. It counts from a programmable reload value down to 0. On reaching 0 it emits a one-cycle done pulse, then either stops or auto-reloads. It is used as a tick/timeout source for later lab FSMs (traffic-light, debounce, LED blink).

---
 rtl/countdown_timer_pkg.sv | 14 +
 rtl/countdown_timer.sv | 91 +++++++++
 tb/tb_countdown_timer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared constants and state encoding for the lab counter/timer blocks.
// The up-counter lab blocks reuse the default width and reload value.
package countdown_timer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LOAD  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with a run/pause FSM and a one-cycle done pulse.
// It either stops at zero or reloads from reload_q, depending on auto_reload.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | stopped; out holds the loaded or terminal value
//   ST_RUN   | out decrements each edge; terminal count fires done
//   ST_PAUSE | out frozen until start arrives without pause
//   2'd3     | illegal; returns to ST_IDLE next edge with out held
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEFAULT_LOAD = DEF_LOAD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] LOAD_INIT = WIDTH'(DEFAULT_LOAD);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_q    <= LOAD_INIT;
      reload_q <= LOAD_INIT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    if (load) begin
      reload_d = load_val;
      out_d    = load_val;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // Starting with out already at zero is a zero-length timer.
          if (start) begin
            if (out_q != '0) state_d = ST_RUN;
            else             done_d  = 1'b1;
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (out_q != '0) begin
            out_d = out_q - WIDTH'(1);
          end else begin
            done_d = 1'b1;
            if (auto_reload) out_d   = reload_q;
            else             state_d = ST_IDLE;
          end
        end
        ST_PAUSE: begin
          if (start && !pause) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: expected values are hand-computed
// from the timer's latency rules and checked with immediate assertions.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       pause;
  logic       auto_reload;
  logic [3:0] out;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.WIDTH(4), .DEFAULT_LOAD(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .pause      (pause),
    .auto_reload(auto_reload),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk(input string tag, input int exp_out, input bit exp_busy, input bit exp_done);
    chk1({tag, ".out"},  32'(out),  32'(exp_out));
    chk1({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    chk1({tag, ".done"}, 32'(done), 32'(exp_done));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0;
    pause = 1'b0; auto_reload = 1'b0;
    step();
    chk("reset", 7, 0, 0);

    // One-shot countdown from the default reload value
    rst = 1'b0; start = 1'b1;
    step();
    chk("oneshot_start", 7, 1, 0);
    start = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      step();
      chk("oneshot_count", i, 1, 0);
    end
    step();
    chk("oneshot_done", 0, 0, 1);
    step();
    chk("oneshot_after", 0, 0, 0);

    // Auto-reload from 3: period of 4 cycles
    load = 1'b1; load_val = 4'd3; auto_reload = 1'b1;
    step();
    chk("ar_load", 3, 0, 0);
    load = 1'b0; start = 1'b1;
    step();
    chk("ar_start", 3, 1, 0);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("ar_cycle", 3 - (i % 4), 1, (i % 4) == 0);
    end
    load = 1'b1; load_val = 4'd5; auto_reload = 1'b0;
    step();
    chk("ar_stop_load", 5, 0, 0);
    load = 1'b0;

    // Pause at 3 for four cycles, then resume
    start = 1'b1;
    step();
    chk("pz_start", 5, 1, 0);
    start = 1'b0;
    step();
    chk("pz_c4", 4, 1, 0);
    step();
    chk("pz_c3", 3, 1, 0);
    pause = 1'b1;
    step();
    chk("pz_enter", 3, 1, 0);
    pause = 1'b0;
    step();
    chk("pz_hold1", 3, 1, 0);
    start = 1'b1; pause = 1'b1;
    step();
    chk("pz_hold_both", 3, 1, 0);
    start = 1'b0; pause = 1'b0;
    step();
    chk("pz_hold3", 3, 1, 0);
    start = 1'b1;
    step();
    chk("pz_resume", 3, 1, 0);
    start = 1'b0;
    step();
    chk("pz_c2", 2, 1, 0);
    step();
    chk("pz_c1", 1, 1, 0);
    step();
    chk("pz_c0", 0, 1, 0);
    step();
    chk("pz_done", 0, 0, 1);

    // load + start together: load wins, no counting
    load = 1'b1; load_val = 4'd6; start = 1'b1;
    step();
    chk("ls_load", 6, 0, 0);
    load = 1'b0; start = 1'b0;
    step();
    chk("ls_idle", 6, 0, 0);

    // pause + start in RUN: pause wins
    start = 1'b1;
    step();
    chk("ps_run", 6, 1, 0);
    start = 1'b0;
    step();
    chk("ps_c5", 5, 1, 0);
    start = 1'b1; pause = 1'b1;
    step();
    chk("ps_pause", 5, 1, 0);
    start = 1'b0; pause = 1'b0;
    step();
    chk("ps_held", 5, 1, 0);
    start = 1'b1;
    step();
    chk("ps_resume", 5, 1, 0);
    start = 1'b0;
    step();
    chk("ps_c4", 4, 1, 0);
    step();
    chk("ps_c3", 3, 1, 0);
    step();
    chk("ps_c2", 2, 1, 0);

    // load during RUN at out=2 aborts without done
    load = 1'b1; load_val = 4'd9;
    step();
    chk("lr_load", 9, 0, 0);
    load = 1'b0;
    step();
    chk("lr_nodone", 9, 0, 0);

    // reset mid-RUN at out=4
    start = 1'b1;
    step();
    chk("rr_start", 9, 1, 0);
    start = 1'b0;
    for (int i = 8; i >= 4; i--) begin
      step();
      chk("rr_count", i, 1, 0);
    end
    rst = 1'b1;
    step();
    chk("rr_reset", 7, 0, 0);
    rst = 1'b0;
    step();
    chk("rr_after", 7, 0, 0);

    // zero-length timer
    load = 1'b1; load_val = 4'd0;
    step();
    chk("zl_load", 0, 0, 0);
    load = 1'b0; start = 1'b1;
    step();
    chk("zl_done", 0, 0, 1);
    start = 1'b0;
    step();
    chk("zl_after", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
